// File: rtl/serial_pkg.sv
// Shared types and constants for the operand stream serializer.
package serial_pkg;

  localparam int SER_W = 8;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_SHIFT,
    SER_PAD
  } ser_state_t;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out register; emits its contents LSB first, filling with zeros.
module piso_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic         q_lsb
);

  logic [W-1:0] shift_q;

  // A load wins over a shift so back-to-back frames can reload on the final bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
    end else if (load) begin
      shift_q <= d;
    end else if (shift) begin
      shift_q <= {1'b0, shift_q[W-1:1]};
    end
  end

  assign q_lsb = shift_q[0];

endmodule

// File: rtl/operand_stream_serializer.sv
// Serializes operand pairs LSB first with zero padding so a downstream
// bit-serial adder can flush its carry before the next frame.
module operand_stream_serializer
  import serial_pkg::*;
#(
  parameter int W        = SER_W,
  parameter int PAD_BITS = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         a_bit,
  output logic         b_bit,
  output logic         bit_valid,
  output logic         first_bit,
  output logic         last_bit,
  output logic         busy
);

  localparam int FRAME = W + PAD_BITS;
  localparam int CNT_W = $clog2(FRAME + 1);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(FRAME - 1);

  ser_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bit_valid_q, bit_valid_d;
  logic             first_bit_q, first_bit_d;
  logic             last_bit_q, last_bit_d;
  logic             accept;
  logic             shift_en;

  assign in_ready = !rst && ((state_q == SER_IDLE) || last_bit_q);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != SER_IDLE);
  assign shift_en = (state_q == SER_SHIFT);

  // cnt_q is the index of the bit currently on the outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      SER_IDLE: begin
        if (accept) begin
          state_d = SER_SHIFT;
          cnt_d   = '0;
        end
      end
      default: begin
        if (cnt_q == TERM) begin
          state_d = accept ? SER_SHIFT : SER_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ((int'(cnt_q) + 1) >= W) ? SER_PAD : SER_SHIFT;
        end
      end
    endcase
    bit_valid_d = (state_d != SER_IDLE);
    first_bit_d = accept;
    last_bit_d  = (state_d != SER_IDLE) && (cnt_d == TERM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SER_IDLE;
      cnt_q       <= '0;
      bit_valid_q <= 1'b0;
      first_bit_q <= 1'b0;
      last_bit_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_valid_q <= bit_valid_d;
      first_bit_q <= first_bit_d;
      last_bit_q  <= last_bit_d;
    end
  end

  // Registers drain to zero after W shifts, so pad and idle bits read as 0.
  piso_shift_reg #(.W(W)) u_shift_a (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .shift(shift_en),
    .d    (op_a),
    .q_lsb(a_bit)
  );

  piso_shift_reg #(.W(W)) u_shift_b (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .shift(shift_en),
    .d    (op_b),
    .q_lsb(b_bit)
  );

  assign bit_valid = bit_valid_q;
  assign first_bit = first_bit_q;
  assign last_bit  = last_bit_q;

endmodule

// File: tb/tb_operand_stream_serializer.sv
// Directed testbench for operand_stream_serializer (W=8/PAD=1 and W=4/PAD=0).
module tb_operand_stream_serializer;

  logic       clk;
  logic       rst;
  logic       in_valid, in_ready;
  logic [7:0] op_a, op_b;
  logic       a_bit, b_bit, bit_valid, first_bit, last_bit, busy;

  logic       in_valid2, in_ready2;
  logic [3:0] op_a2, op_b2;
  logic       a_bit2, b_bit2, bit_valid2, first_bit2, last_bit2, busy2;

  int assertCount = 0;
  int failCount   = 0;

  operand_stream_serializer #(.W(8), .PAD_BITS(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .a_bit(a_bit), .b_bit(b_bit),
    .bit_valid(bit_valid), .first_bit(first_bit), .last_bit(last_bit), .busy(busy)
  );

  operand_stream_serializer #(.W(4), .PAD_BITS(0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .op_a(op_a2), .op_b(op_b2), .a_bit(a_bit2), .b_bit(b_bit2),
    .bit_valid(bit_valid2), .first_bit(first_bit2), .last_bit(last_bit2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    stepCycle();
    in_valid = 1'b0;
    op_a     = '0;
    op_b     = '0;
  endtask

  // Checks a full 9-cycle frame and a bench-side serial adder's sum stream.
  task automatic checkFrame(input logic [8:0] expA, input logic [8:0] expB, input logic [8:0] expSum);
    logic       carry;
    logic [8:0] sum;
    carry = 1'b0;
    sum   = '0;
    for (int i = 0; i < 9; i++) begin
      checkOutput($sformatf("a_bit[%0d]", i), 32'(a_bit), 32'(expA[i]));
      checkOutput($sformatf("b_bit[%0d]", i), 32'(b_bit), 32'(expB[i]));
      checkOutput($sformatf("bit_valid[%0d]", i), 32'(bit_valid), 32'd1);
      checkOutput($sformatf("first_bit[%0d]", i), 32'(first_bit), 32'(i == 0));
      checkOutput($sformatf("last_bit[%0d]", i), 32'(last_bit), 32'(i == 8));
      if (bit_valid) begin
        sum[i] = a_bit ^ b_bit ^ carry;
        carry  = (a_bit & b_bit) | (a_bit & carry) | (b_bit & carry);
      end else begin
        carry = 1'b0;
      end
      stepCycle();
    end
    checkOutput("sum_stream", 32'(sum), 32'(expSum));
    checkOutput("post_frame_valid", 32'(bit_valid), 32'd0);
    checkOutput("post_frame_busy", 32'(busy), 32'd0);
    checkOutput("post_frame_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [8:0]  expA, expB;
    logic [17:0] expA18, expB18;
    int          validCount, firstCount;

    rst       = 1'b1;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    in_valid2 = 1'b0;
    op_a2     = '0;
    op_b2     = '0;
    stepCycle();
    stepCycle();
    checkOutput("rst_a_bit", 32'(a_bit), 32'd0);
    checkOutput("rst_bit_valid", 32'(bit_valid), 32'd0);
    checkOutput("rst_first_last", 32'({first_bit, last_bit}), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_in_ready2", 32'(in_ready2), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("idle_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] basic frame B5/6E");
    applyStimulus(8'hB5, 8'h6E);
    checkFrame(9'h0B5, 9'h06E, 9'h123);

    $display("[TB] carry flush FF/01");
    applyStimulus(8'hFF, 8'h01);
    checkFrame(9'h0FF, 9'h001, 9'h100);

    $display("[TB] back-to-back frames");
    in_valid = 1'b1;
    op_a     = 8'h3C;
    op_b     = 8'hC3;
    stepCycle();
    op_a       = 8'h81;
    op_b       = 8'h7E;
    expA18     = {1'b0, 8'h81, 1'b0, 8'h3C};
    expB18     = {1'b0, 8'h7E, 1'b0, 8'hC3};
    validCount = 0;
    firstCount = 0;
    for (int i = 0; i < 18; i++) begin
      checkOutput($sformatf("b2b_a[%0d]", i), 32'(a_bit), 32'(expA18[i]));
      checkOutput($sformatf("b2b_b[%0d]", i), 32'(b_bit), 32'(expB18[i]));
      checkOutput($sformatf("b2b_first[%0d]", i), 32'(first_bit), 32'((i == 0) || (i == 9)));
      checkOutput($sformatf("b2b_last[%0d]", i), 32'(last_bit), 32'((i == 8) || (i == 17)));
      if (i == 8) checkOutput("b2b_ready_at_last", 32'(in_ready), 32'd1);
      if (i == 3) checkOutput("b2b_ready_mid", 32'(in_ready), 32'd0);
      validCount += int'(bit_valid);
      firstCount += int'(first_bit);
      if (i == 9) in_valid = 1'b0;
      stepCycle();
    end
    checkOutput("b2b_valid_count", 32'(validCount), 32'd18);
    checkOutput("b2b_first_count", 32'(firstCount), 32'd2);
    checkOutput("b2b_end_valid", 32'(bit_valid), 32'd0);

    $display("[TB] in_valid toggling while busy");
    applyStimulus(8'h5A, 8'h0F);
    expA = 9'h05A;
    expB = 9'h00F;
    for (int i = 0; i < 9; i++) begin
      checkOutput($sformatf("busy_a[%0d]", i), 32'(a_bit), 32'(expA[i]));
      checkOutput($sformatf("busy_b[%0d]", i), 32'(b_bit), 32'(expB[i]));
      checkOutput($sformatf("busy_ready[%0d]", i), 32'(in_ready), 32'(i == 8));
      in_valid = ((i + 1) < 8) && ((i % 2) == 0);
      op_a     = 8'(i * 37 + 3);
      op_b     = 8'(i * 11 + 1);
      stepCycle();
    end
    in_valid = 1'b0;
    checkOutput("busy_no_extra_frame", 32'(busy), 32'd0);

    $display("[TB] reset mid-frame");
    applyStimulus(8'hB5, 8'h6E);
    for (int i = 0; i < 4; i++) stepCycle();
    checkOutput("pre_rst_a_bit4", 32'(a_bit), 32'd1);
    rst = 1'b1;
    stepCycle();
    checkOutput("abort_outputs", 32'({a_bit, b_bit, bit_valid, first_bit, last_bit}), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_ready_in_rst", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("abort_ready_after", 32'(in_ready), 32'd1);
    applyStimulus(8'h01, 8'h01);
    checkFrame(9'h001, 9'h001, 9'h002);

    $display("[TB] W=4 PAD_BITS=0");
    in_valid2 = 1'b1;
    op_a2     = 4'hA;
    op_b2     = 4'h5;
    stepCycle();
    in_valid2  = 1'b0;
    validCount = 0;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("w4_a[%0d]", i), 32'(a_bit2), 32'(i % 2));
      checkOutput($sformatf("w4_b[%0d]", i), 32'(b_bit2), 32'((i + 1) % 2));
      checkOutput($sformatf("w4_first[%0d]", i), 32'(first_bit2), 32'(i == 0));
      checkOutput($sformatf("w4_last[%0d]", i), 32'(last_bit2), 32'(i == 3));
      validCount += int'(bit_valid2);
      stepCycle();
    end
    checkOutput("w4_valid_count", 32'(validCount), 32'd4);
    checkOutput("w4_end_valid", 32'(bit_valid2), 32'd0);
    checkOutput("w4_end_busy", 32'(busy2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
